kronos_sram: RTL and testbench

Parametrised single-port word memory with a req/ack handshake. It is the generalised successor of the fixed 4KB platform memory. It adds configurable data width and depth, an optional extra read pipeline stage, and a post-reset zero-fill sequencer. It sits on the core's instruction/data bus as main memory and is inferred as EBR/BRAM.

---
 rtl/kronos_mem_pkg.sv | 20 ++
 rtl/kronos_sram_array.sv | 42 ++++
 rtl/kronos_sram.sv | 192 +++++++++++++++++++
 tb/tb_kronos_sram.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_mem_pkg.sv
// kronos_mem_pkg: shared types and helpers for the kronos_sram memory.
// Holds the controller state encoding, the legal read-latency range and
// the even-parity helper used when KRONOS_SRAM_PARITY_EN is defined.
package kronos_mem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BUSY  = 2'd2
   } state_e;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

   // Even parity: the stored bit makes the 9-bit lane contain an even number of ones.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/kronos_sram_array.sv
// kronos_sram_array: raw DEPTH x (NB*LW) storage for kronos_sram.
// Each word is NB lanes of LW bits (8 data bits, plus one parity bit when
// parity is enabled), written per lane under a byte mask. Reads are
// registered and only update on a read enable, so the output holds the
// last word read. No reset on the storage so it maps onto block RAM.
module kronos_sram_array
   import kronos_mem_pkg::*;
#(
   parameter int    NB        = 4,
   parameter int    LW        = 8,
   parameter int    AW        = 10,
   parameter string INIT_FILE = ""
) (
   input  logic               clk,
   input  logic [AW-1:0]      addr,
   input  logic               we,
   input  logic [NB-1:0]      be,
   input  logic [NB*LW-1:0]   wdata,
   input  logic               re,
   output logic [NB*LW-1:0]   rdata
);

   logic [NB*LW-1:0] mem [0:(2**AW)-1];
   logic [NB*LW-1:0] rdata_q;

   // Byte-lane masked write and synchronous read port.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
            end
         end
      end
      if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/kronos_sram.sv
// kronos_sram: parametrised single-port word memory with req/ack handshake.
// Controller FSM (CLEAR/IDLE/BUSY), post-reset zero-fill, read-latency
// counter and optional output register. Define KRONOS_SRAM_PARITY_EN to
// store one even-parity bit per byte and report mismatches on mem_err.
module kronos_sram
   import kronos_mem_pkg::*;
#(
   parameter int    DW             = 32,
   parameter int    AW             = 10,
   parameter int    READ_LAT       = 1,
   parameter int    CLEAR_ON_RESET = 1,
   parameter string INIT_FILE      = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       mem_addr,
   input  logic [DW-1:0]     mem_wdata,
   input  logic [DW/8-1:0]   mem_mask,
   input  logic              mem_we,
   input  logic              mem_req,
   output logic              mem_ack,
   output logic [DW-1:0]     mem_rdata,
   output logic              mem_err,
   output logic              mem_ready
);

   localparam int NB  = DW / 8;
   localparam int BL  = $clog2(NB);
   localparam int LAT = (READ_LAT >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;
`ifdef KRONOS_SRAM_PARITY_EN
   localparam int LW  = 9;
`else
   localparam int LW  = 8;
`endif
   localparam logic [AW-1:0] LAST_WORD = {AW{1'b1}};

   state_e          state_q, state_d;
   logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
   logic            cnt_q, cnt_d;
   logic            ack_q, ack_d;
   logic            rd_q, rd_d;
   logic            ready_q, ready_d;
   logic            valid_q, valid_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            perr_q, perr_d;

   logic            accept;
   logic [AW-1:0]   arr_addr;
   logic            arr_we;
   logic            arr_re;
   logic [NB-1:0]   arr_be;
   logic [NB*LW-1:0] arr_wdata;
   logic [NB*LW-1:0] arr_rdata;
   logic [DW-1:0]   rd_word;
   logic            rd_perr;

   // Address bits outside the word index are deliberately ignored.
   logic addr_unused;
   assign addr_unused = ^mem_addr;

   assign accept = (state_q == ST_IDLE) && mem_req;

   // State register: all controller flops, reset synchronously.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         clr_ptr_q <= '0;
         cnt_q     <= 1'b0;
         ack_q     <= 1'b0;
         rd_q      <= 1'b0;
         ready_q   <= (CLEAR_ON_RESET == 0);
         valid_q   <= 1'b0;
         rdata_q   <= '0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         rd_q      <= rd_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         rdata_q   <= rdata_d;
         perr_q    <= perr_d;
      end
   end

   // Next-state logic: clear walk, request acceptance and latency countdown.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      ready_d   = ready_q;
      valid_d   = valid_q;
      rdata_d   = rdata_q;
      perr_d    = perr_q;
      case (state_q)
         ST_CLEAR: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_WORD) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_BUSY;
               rd_d    = !mem_we;
               cnt_d   = !mem_we && (LAT == 2);
               if (!mem_we) begin
                  valid_d = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == 1'b0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (rd_q) begin
                  rdata_d = rd_word;
                  perr_d  = rd_perr;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ack_d = (state_d == ST_BUSY) && (cnt_d == 1'b0);
   end

   // Output logic: array port muxing between the clear walker and the bus.
   always_comb begin
      arr_addr = mem_addr[BL +: AW];
      arr_we   = 1'b0;
      arr_re   = 1'b0;
      arr_be   = mem_mask;
      for (int i = 0; i < NB; i++) begin
`ifdef KRONOS_SRAM_PARITY_EN
         arr_wdata[i*LW +: LW] = {byte_parity(mem_wdata[i*8 +: 8]), mem_wdata[i*8 +: 8]};
`else
         arr_wdata[i*LW +: LW] = mem_wdata[i*8 +: 8];
`endif
      end
      if (state_q == ST_CLEAR) begin
         arr_addr  = clr_ptr_q;
         arr_we    = 1'b1;
         arr_be    = '1;
         arr_wdata = '0;
      end else if (accept) begin
         arr_we = mem_we;
         arr_re = !mem_we;
      end
   end

   // Output logic: strip lanes back to data bytes and check stored parity.
   always_comb begin
      rd_word = '0;
      rd_perr = 1'b0;
      for (int i = 0; i < NB; i++) begin
         rd_word[i*8 +: 8] = arr_rdata[i*LW +: 8];
`ifdef KRONOS_SRAM_PARITY_EN
         if (arr_rdata[i*LW + 8] != byte_parity(arr_rdata[i*LW +: 8])) begin
            rd_perr = 1'b1;
         end
`endif
      end
   end

   kronos_sram_array #(
      .NB        (NB),
      .LW        (LW),
      .AW        (AW),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .addr  (arr_addr),
      .we    (arr_we),
      .be    (arr_be),
      .wdata (arr_wdata),
      .re    (arr_re),
      .rdata (arr_rdata)
   );

   // With one cycle of latency the array register is the output; valid_q
   // masks stale array contents so rdata reads zero until the first read.
   assign mem_ack   = ack_q;
   assign mem_rdata = (LAT == 2) ? rdata_q : (valid_q ? rd_word : '0);
   assign mem_err   = ack_q && rd_q && ((LAT == 2) ? perr_q : rd_perr);
   assign mem_ready = ready_q;

endmodule

// File: tb/tb_kronos_sram.sv
// tb_kronos_sram: scoreboard bench for kronos_sram.
// dut1: default build (DW=32, AW=10, READ_LAT=1, CLEAR_ON_RESET=1).
// dut2: short memory (AW=4) with READ_LAT=2.
// Define KRONOS_SRAM_PARITY_EN to include the parity-error checks.
module tb_kronos_sram;

   typedef struct {
      string       name;
      logic        isRead;
      logic [31:0] data;
      logic        err;
   } scb_t;

   logic        clk = 1'b0;
   logic        rst1, rst2;
   logic [31:0] addr1, wdata1, addr2, wdata2;
   logic [3:0]  mask1, mask2;
   logic        we1, req1, we2, req2;
   logic        ack1, err1, ready1, ack2, err2, ready2;
   logic [31:0] rdata1, rdata2;

   scb_t q1[$];
   scb_t q2[$];
   int   testsRun    = 0;
   int   testsFailed = 0;

   always #5 clk = ~clk;

   kronos_sram #(
      .DW(32), .AW(10), .READ_LAT(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
   ) dut1 (
      .clk(clk), .rst(rst1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_mask(mask1),
      .mem_we(we1), .mem_req(req1), .mem_ack(ack1), .mem_rdata(rdata1),
      .mem_err(err1), .mem_ready(ready1)
   );

   kronos_sram #(
      .DW(32), .AW(4), .READ_LAT(2), .CLEAR_ON_RESET(1), .INIT_FILE("")
   ) dut2 (
      .clk(clk), .rst(rst2), .mem_addr(addr2), .mem_wdata(wdata2), .mem_mask(mask2),
      .mem_we(we2), .mem_req(req2), .mem_ack(ack2), .mem_rdata(rdata2),
      .mem_err(err2), .mem_ready(ready2)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Issue one transaction, record its expected response, wait for ack and check latency.
   task automatic applyStimulus(input int sel, input string name, input logic [31:0] addr,
                                input logic we, input logic [31:0] wdata, input logic [3:0] mask,
                                input logic [31:0] expData, input logic expErr, input int expLat);
      scb_t e;
      int   lat;
      logic seen;
      e.name   = name;
      e.isRead = !we;
      e.data   = expData;
      e.err    = expErr;
      @(negedge clk);
      if (sel == 1) begin
         q1.push_back(e);
         addr1 = addr; we1 = we; wdata1 = wdata; mask1 = mask; req1 = 1'b1;
      end else begin
         q2.push_back(e);
         addr2 = addr; we2 = we; wdata2 = wdata; mask2 = mask; req2 = 1'b1;
      end
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         seen = (sel == 1) ? ack1 : ack2;
      end
      if (!seen) checkOutput({name, " ack timeout"}, 32'd0, 32'd1);
      else       checkOutput({name, " ack latency"}, lat, expLat);
      @(negedge clk);
      if (sel == 1) req1 = 1'b0;
      else          req2 = 1'b0;
   endtask

   // Count cycles from reset release until mem_ready, watching for stray acks.
   task automatic waitReady(input int sel, input int expCycles, input string name);
      int   cnt;
      logic rdy;
      logic early;
      cnt   = 0;
      rdy   = 1'b0;
      early = 1'b0;
      while (!rdy && cnt < 5000) begin
         @(posedge clk);
         #1;
         cnt++;
         rdy = (sel == 1) ? ready1 : ready2;
         if (!rdy && ((sel == 1) ? ack1 : ack2)) early = 1'b1;
      end
      checkOutput({name, " ready cycles"}, cnt, expCycles);
      checkOutput({name, " no ack during clear"}, early, 1'b0);
   endtask

   // Monitor for dut1: every ack pops one expected response.
   always @(negedge clk) begin
      scb_t e;
      if (ack1) begin
         if (q1.size() == 0) begin
            checkOutput("dut1 unexpected ack", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            if (e.isRead) checkOutput({e.name, " rdata"}, rdata1, e.data);
            checkOutput({e.name, " err"}, err1, e.err);
         end
      end
   end

   // Monitor for dut2.
   always @(negedge clk) begin
      scb_t e;
      if (ack2) begin
         if (q2.size() == 0) begin
            checkOutput("dut2 unexpected ack", 32'd1, 32'd0);
         end else begin
            e = q2.pop_front();
            if (e.isRead) checkOutput({e.name, " rdata"}, rdata2, e.data);
            checkOutput({e.name, " err"}, err2, e.err);
         end
      end
   end

   initial begin
      scb_t e;
      int   lat;
      rst1 = 1'b1; rst2 = 1'b1;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; mask1 = '0;
      req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; mask2 = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("dut1 reset ack",   ack1,   1'b0);
      checkOutput("dut1 reset rdata", rdata1, 32'h0);
      checkOutput("dut1 reset err",   err1,   1'b0);
      checkOutput("dut1 reset ready", ready1, 1'b0);

      @(negedge clk);
      rst1 = 1'b0;
      waitReady(1, 1024, "dut1 clear");

      applyStimulus(1, "w 0xFFC",       32'h0FFC, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1);
      applyStimulus(1, "r 0xFFC",       32'h0FFC, 1'b0, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1);
      applyStimulus(1, "w 0x10 full",   32'h10,   1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1);
      applyStimulus(1, "w 0x10 byte1",  32'h10,   1'b1, 32'h0000AA00, 4'h2, 32'h0,        1'b0, 1);
      applyStimulus(1, "r 0x10 merged", 32'h10,   1'b0, 32'h0,        4'h0, 32'hDEADAAEF, 1'b0, 1);
      applyStimulus(1, "w 0x10 mask0",  32'h10,   1'b1, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1);
      applyStimulus(1, "r 0x10 mask0",  32'h10,   1'b0, 32'h0,        4'h0, 32'hDEADAAEF, 1'b0, 1);
      applyStimulus(1, "w 0x1010 alias",32'h1010, 1'b1, 32'h11223344, 4'hF, 32'h0,        1'b0, 1);
      checkOutput("dut1 rdata held after write", rdata1, 32'hDEADAAEF);
      applyStimulus(1, "r 0x13 alias",  32'h13,   1'b0, 32'h0,        4'h0, 32'h11223344, 1'b0, 1);

`ifdef KRONOS_SRAM_PARITY_EN
      applyStimulus(1, "w 0x14 parity", 32'h14,   1'b1, 32'h0F0F0F0F, 4'hF, 32'h0,        1'b0, 1);
      @(negedge clk);
      dut1.u_array.mem[5][8] = ~dut1.u_array.mem[5][8];
      applyStimulus(1, "r 0x14 bad parity",  32'h14, 1'b0, 32'h0, 4'h0, 32'h0F0F0F0F, 1'b1, 1);
      applyStimulus(1, "r 0x10 good parity", 32'h10, 1'b0, 32'h0, 4'h0, 32'h11223344, 1'b0, 1);
`endif

      // Second reset with a read held through CLEAR: served only once ready, sees zero.
      @(negedge clk);
      rst1 = 1'b1;
      addr1 = 32'h0FFC; we1 = 1'b0; mask1 = 4'h0; req1 = 1'b1;
      e.name = "clear read 0xFFC"; e.isRead = 1'b1; e.data = 32'h0; e.err = 1'b0;
      q1.push_back(e);
      @(negedge clk);
      rst1 = 1'b0;
      waitReady(1, 1024, "dut1 reclear");
      lat = 0;
      while (!ack1 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("dut1 ack after ready", lat, 1);
      @(negedge clk);
      req1 = 1'b0;

      // dut2: READ_LAT=2 behaviour and reset abandoning a pending read.
      @(negedge clk);
      rst2 = 1'b0;
      waitReady(2, 16, "dut2 clear");
      applyStimulus(2, "dut2 w 0x20", 32'h20, 1'b1, 32'h12345678, 4'hF, 32'h0,        1'b0, 1);
      applyStimulus(2, "dut2 r 0x20", 32'h20, 1'b0, 32'h0,        4'h0, 32'h12345678, 1'b0, 2);

      @(negedge clk);
      addr2 = 32'h20; we2 = 1'b0; mask2 = 4'h0; req2 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("dut2 no ack in accept cycle", ack2, 1'b0);
      @(negedge clk);
      rst2 = 1'b1;
      req2 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("dut2 abandoned ack",   ack2,   1'b0);
      checkOutput("dut2 rdata after rst", rdata2, 32'h0);
      checkOutput("dut2 ready after rst", ready2, 1'b0);
      @(negedge clk);
      rst2 = 1'b0;
      waitReady(2, 16, "dut2 reclear");
      applyStimulus(2, "dut2 r 0x20 cleared", 32'h20, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 2);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("dut1 scoreboard drained", q1.size(), 32'd0);
      checkOutput("dut2 scoreboard drained", q2.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
